// File: rtl/port_default_sequencer_pkg.sv
// Shared types for the port default sequencer.
//   seq_state_t  : sequencer FSM states
//   cmd_t        : queued command {abc, hold} at the default hold width
//   abc_default(): packs the three per-port defaults into a/b/c bit order
package port_default_sequencer_pkg;

  localparam int HOLD_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [2:0]            abc;   // bit2=a, bit1=b, bit0=c
    logic [HOLD_WIDTH-1:0] hold;
  } cmd_t;

  function automatic logic [2:0] abc_default(input logic a, input logic b, input logic c);
    return {a, b, c};
  endfunction

endpackage

// File: rtl/port_default_seq_fifo.sv
// Small synchronous first-word-fall-through FIFO for queued commands.
// Ports:
//   i_clk, i_rst (async active-low)
//   i_push/i_wdata : write side, ignored while full
//   i_pop/o_rdata  : read side, o_rdata is the head entry, pop ignored while empty
//   o_full/o_empty : occupancy flags
// DEPTH must be a power of two, >= 2; pointers carry one extra wrap bit.
module port_default_seq_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             push_ok, pop_ok;

  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop_ok)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/port_default_sequencer.sv
// Stimulus sequencer for a downstream unit with controls a/b/c and result d.
// Commands are queued, each drives a/b/c for 'hold' cycles (0 acts as 1),
// d is sampled on the last drive cycle and returned on a valid/ready channel.
// Ports:
//   i_clk, i_rst (async active-low)
//   i_cmd_valid/o_cmd_ready, i_cmd_abc, i_cmd_hold : command channel
//   o_a, o_b, o_c, i_d                             : downstream unit
//   o_rsp_valid/i_rsp_ready, o_rsp_d               : response channel
//   o_busy                                         : work queued or in flight
//   o_cmd_count (only with PORT_DEFAULT_SEQUENCER_CMD_COUNT_EN defined):
//     saturating count of completed response handshakes.
module port_default_sequencer #(
  parameter logic DEFAULT_A  = 1'b0,
  parameter logic DEFAULT_B  = 1'b0,
  parameter logic DEFAULT_C  = 1'b0,
  parameter int   HOLD_WIDTH = 4,
  parameter int   FIFO_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2:0]            i_cmd_abc,
  input  logic [HOLD_WIDTH-1:0] i_cmd_hold,
  output logic                  o_a,
  output logic                  o_b,
  output logic                  o_c,
  input  logic                  i_d,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_d,
`ifdef PORT_DEFAULT_SEQUENCER_CMD_COUNT_EN
  output logic [15:0]           o_cmd_count,
`endif
  output logic                  o_busy
);

  import port_default_sequencer_pkg::*;

  localparam int                  CW       = 3 + HOLD_WIDTH;
  localparam logic [2:0]          ABC_DEF  = abc_default(DEFAULT_A, DEFAULT_B, DEFAULT_C);
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

  seq_state_t              state_q, state_d;
  logic [2:0]              abc_q;
  logic [HOLD_WIDTH-1:0]   cnt_q;
  logic                    rsp_d_q;
  logic [CW-1:0]           fifo_rdata;
  logic                    fifo_full, fifo_empty, pop;
  logic [2:0]              head_abc;
  logic [HOLD_WIDTH-1:0]   head_hold;
  logic                    last_drive;

  port_default_seq_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_cmd_valid),
    .i_wdata ({i_cmd_abc, i_cmd_hold}),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_cmd_ready = !fifo_full;
  assign head_abc    = fifo_rdata[CW-1 -: 3];
  assign head_hold   = fifo_rdata[HOLD_WIDTH-1:0];
  assign pop         = (state_q == IDLE) && !fifo_empty;
  // cnt_q is never 0 in DRIVE; treat <=1 as last to stay safe anyway
  assign last_drive  = (state_q == DRIVE) && (cnt_q <= HOLD_ONE);

  // state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = DRIVE;
      DRIVE:   if (last_drive)  state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    {o_a, o_b, o_c} = ABC_DEF;
    o_rsp_valid     = 1'b0;
    if (state_q == DRIVE) {o_a, o_b, o_c} = abc_q;
    if (state_q == RESP)  o_rsp_valid = 1'b1;
  end

  assign o_rsp_d = rsp_d_q;
  assign o_busy  = (state_q != IDLE) || !fifo_empty;

  // current command, hold counter and captured result
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      abc_q   <= '0;
      cnt_q   <= '0;
      rsp_d_q <= 1'b0;
    end else if (pop) begin
      abc_q <= head_abc;
      cnt_q <= (head_hold == '0) ? HOLD_ONE : head_hold;
    end else if (state_q == DRIVE) begin
      cnt_q <= cnt_q - HOLD_ONE;
      if (last_drive) rsp_d_q <= i_d;
    end
  end

`ifdef PORT_DEFAULT_SEQUENCER_CMD_COUNT_EN
  logic [15:0] cmd_count_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      cmd_count_q <= '0;
    else if (o_rsp_valid && i_rsp_ready && (cmd_count_q != 16'hFFFF))
      cmd_count_q <= cmd_count_q + 16'd1;
  end

  assign o_cmd_count = cmd_count_q;
`endif

endmodule

// File: tb/tb_port_default_sequencer.sv
module tb_port_default_sequencer;

  import port_default_sequencer_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [2:0] i_cmd_abc = '0;
  logic [3:0] i_cmd_hold = '0;
  logic       o_a, o_b, o_c;
  logic       i_d = 1'b0;
  logic       o_rsp_valid;
  logic       i_rsp_ready = 1'b0;
  logic       o_rsp_d;
  logic       o_busy;
`ifdef PORT_DEFAULT_SEQUENCER_CMD_COUNT_EN
  logic [15:0] o_cmd_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;

  port_default_sequencer #(
    .DEFAULT_A(1'b0), .DEFAULT_B(1'b0), .DEFAULT_C(1'b0),
    .HOLD_WIDTH(4), .FIFO_DEPTH(2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_abc   (i_cmd_abc),
    .i_cmd_hold  (i_cmd_hold),
    .o_a         (o_a),
    .o_b         (o_b),
    .o_c         (o_c),
    .i_d         (i_d),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_d     (o_rsp_d),
`ifdef PORT_DEFAULT_SEQUENCER_CMD_COUNT_EN
    .o_cmd_count (o_cmd_count),
`endif
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    cmd_t       cmd;
    logic       d;
    int         drv;      // cycles the command is expected on a/b/c
    logic [2:0] exp_abc;
    logic       exp_d;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!o_rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check({name, "_rsp_timeout"}, {31'd0, o_rsp_valid}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{'{3'b101, 4'd3},  1'b1, 3,  3'b101, 1'b1};
    vecs[1] = '{'{3'b010, 4'd0},  1'b0, 1,  3'b010, 1'b0};
    vecs[2] = '{'{3'b111, 4'd1},  1'b1, 1,  3'b111, 1'b1};
    vecs[3] = '{'{3'b011, 4'd15}, 1'b0, 15, 3'b011, 1'b0};
    vecs[4] = '{'{3'b100, 4'd2},  1'b1, 2,  3'b100, 1'b1};

    // reset state
    repeat (3) tick();
    check("rst_abc",   {29'd0, o_a, o_b, o_c}, 32'd0);
    check("rst_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_rspd",  {31'd0, o_rsp_d}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
    check("rst_ready", {31'd0, o_cmd_ready}, 32'd1);

    // reset asserted mid-DRIVE aborts the command
    i_rsp_ready = 1'b1;
    i_cmd_abc = 3'b111; i_cmd_hold = 4'd5; i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    check("abort_drive_abc", {29'd0, o_a, o_b, o_c}, 32'h7);
    #2 i_rst = 1'b0;
    #1;
    check("abort_abc",   {29'd0, o_a, o_b, o_c}, 32'd0);
    check("abort_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("abort_busy",  {31'd0, o_busy}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("abort_no_rsp",  {31'd0, o_rsp_valid}, 32'd0);
      check("abort_no_busy", {31'd0, o_busy}, 32'd0);
    end

    // table-driven single commands, cycle-exact
    for (int v = 0; v < 5; v++) begin
      i_cmd_abc   = vecs[v].cmd.abc;
      i_cmd_hold  = vecs[v].cmd.hold;
      i_d         = vecs[v].d;
      i_rsp_ready = 1'b1;
      i_cmd_valid = 1'b1;
      check("vec_ready", {31'd0, o_cmd_ready}, 32'd1);
      tick();
      i_cmd_valid = 1'b0;
      for (int k = 1; k <= vecs[v].drv + 2; k++) begin
        if (k >= 2 && k <= vecs[v].drv + 1)
          check($sformatf("vec%0d_abc_k%0d", v, k), {29'd0, o_a, o_b, o_c}, {29'd0, vecs[v].exp_abc});
        else
          check($sformatf("vec%0d_dflt_k%0d", v, k), {29'd0, o_a, o_b, o_c}, 32'd0);
        check($sformatf("vec%0d_valid_k%0d", v, k), {31'd0, o_rsp_valid},
              (k == vecs[v].drv + 2) ? 32'd1 : 32'd0);
        check($sformatf("vec%0d_busy_k%0d", v, k), {31'd0, o_busy}, 32'd1);
        if (k == vecs[v].drv + 2) begin
          check($sformatf("vec%0d_rspd", v), {31'd0, o_rsp_d}, {31'd0, vecs[v].exp_d});
          n_rsp++;
        end
        tick();
      end
      check($sformatf("vec%0d_end_valid", v), {31'd0, o_rsp_valid}, 32'd0);
      check($sformatf("vec%0d_end_busy", v), {31'd0, o_busy}, 32'd0);
    end

    // FIFO full under response backpressure, then in-order drain
    i_rsp_ready = 1'b0;
    i_d = 1'b1;
    i_cmd_hold = 4'd5;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_ready_push%0d", i), {31'd0, o_cmd_ready}, 32'd1);
      i_cmd_abc = 3'(i + 1);
      i_cmd_valid = 1'b1;
      tick();
    end
    i_cmd_valid = 1'b0;
    check("full_ready_low", {31'd0, o_cmd_ready}, 32'd0);
    check("full_busy",      {31'd0, o_busy}, 32'd1);
    wait_rsp("full_c0");
    check("full_c0_d", {31'd0, o_rsp_d}, 32'd1);
    i_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", {31'd0, o_rsp_valid}, 32'd1);
      check("bp_rspd",  {31'd0, o_rsp_d}, 32'd1);
      check("bp_abc",   {29'd0, o_a, o_b, o_c}, 32'd0);
      check("bp_ready", {31'd0, o_cmd_ready}, 32'd0);
    end
    i_rsp_ready = 1'b1;
    tick();
    n_rsp++;
    check("drain_c0_done", {31'd0, o_rsp_valid}, 32'd0);
    wait_rsp("full_c1");
    check("full_c1_d", {31'd0, o_rsp_d}, 32'd0);
    i_d = 1'b1;
    tick();
    n_rsp++;
    wait_rsp("full_c2");
    check("full_c2_d", {31'd0, o_rsp_d}, 32'd1);
    tick();
    n_rsp++;
    check("drain_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("drain_busy",  {31'd0, o_busy}, 32'd0);
    check("drain_ready", {31'd0, o_cmd_ready}, 32'd1);

`ifdef PORT_DEFAULT_SEQUENCER_CMD_COUNT_EN
    check("cmd_count", {16'd0, o_cmd_count}, 32'd8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
